// File: rtl/lsu_ctrl_pkg.sv
// Shared LSU definitions: FSM states, dmem byte-lane selects, mcause codes, func3 opcodes.
package lsu_ctrl_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_RESP = 2'd2} lsu_state_e;

  localparam logic [7:0] WSEL_B = 8'h01;
  localparam logic [7:0] WSEL_H = 8'h03;
  localparam logic [7:0] WSEL_W = 8'h0F;
  localparam logic [7:0] WSEL_D = 8'hFF;

  localparam logic [3:0] EXC_ILLEGAL     = 4'd2;
  localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
  localparam logic [3:0] EXC_LD_FAULT    = 4'd5;
  localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
  localparam logic [3:0] EXC_ST_FAULT    = 4'd7;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Access size (func3[1:0]) to dmem byte-lane select.
  function automatic logic [7:0] wsel_of(input logic [1:0] sz);
    case (sz)
      2'b00:   return WSEL_B;
      2'b01:   return WSEL_H;
      2'b10:   return WSEL_W;
      default: return WSEL_D;
    endcase
  endfunction
endpackage

// File: rtl/lsu_ctrl_if.sv
// LSU bus bundle: execute request, dmem access and writeback response.
// slave = LSU side, master = surrounding pipeline / memory side.
interface lsu_ctrl_if #(parameter int XLEN = 64, parameter int RD_W = 5);
  logic            req_valid;
  logic            req_ready;
  logic            req_is_load;
  logic            req_is_store;
  logic [2:0]      req_func3;
  logic [XLEN-1:0] req_base;
  logic [XLEN-1:0] req_imm;
  logic [XLEN-1:0] req_wdata;
  logic [RD_W-1:0] req_rd;

  logic            we_dmem;
  logic            is_LOAD;
  logic [7:0]      dmem_word_sel;
  logic [XLEN-1:0] r_dmem_addr;
  logic [XLEN-1:0] w_dmem_data;
  logic [2:0]      func3;
  logic [XLEN-1:0] dmem_data;
  logic            exc_en;
  logic [3:0]      exc_code;
  logic [XLEN-1:0] exc_val;

  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;
  logic [RD_W-1:0] resp_rd;
  logic            resp_is_load;
  logic            resp_exc;
  logic [3:0]      resp_exc_code;
  logic [XLEN-1:0] resp_exc_val;

  modport slave (
    input  req_valid, req_is_load, req_is_store, req_func3, req_base, req_imm, req_wdata, req_rd,
    output req_ready,
    output we_dmem, is_LOAD, dmem_word_sel, r_dmem_addr, w_dmem_data, func3,
    input  dmem_data, exc_en, exc_code, exc_val,
    output resp_valid, resp_data, resp_rd, resp_is_load, resp_exc, resp_exc_code, resp_exc_val,
    input  resp_ready
  );

  modport master (
    output req_valid, req_is_load, req_is_store, req_func3, req_base, req_imm, req_wdata, req_rd,
    input  req_ready,
    input  we_dmem, is_LOAD, dmem_word_sel, r_dmem_addr, w_dmem_data, func3,
    output dmem_data, exc_en, exc_code, exc_val,
    input  resp_valid, resp_data, resp_rd, resp_is_load, resp_exc, resp_exc_code, resp_exc_val,
    output resp_ready
  );
endinterface

// File: rtl/lsu_ctrl_addr_gen.sv
// Combinational request decode: effective address, byte-lane select, illegal-op flag.
module lsu_ctrl_addr_gen
  import lsu_ctrl_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] base,
  input  logic [XLEN-1:0] imm,
  input  logic [2:0]      func3,
  input  logic            is_load,
  input  logic            is_store,
  output logic [XLEN-1:0] addr,
  output logic [7:0]      word_sel,
  output logic            illegal
);
  assign addr     = base + imm;
  assign word_sel = wsel_of(func3[1:0]);
  // No unsigned 64b load (111), no store variants with func3[2] set, op type must be unique.
  assign illegal  = (is_load && is_store) ||
                    (is_load && func3 == 3'b111) ||
                    (is_store && func3[2]);
endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: one outstanding op, IDLE -> ISSUE -> RESP.
// Optional LSU_PERF_CNT_EN adds per-type 64b handshake counters.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int RD_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  lsu_ctrl_if.slave   bus
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [63:0] cnt_load,
  output logic [63:0] cnt_store,
  output logic [63:0] cnt_exc
`endif
);
  typedef struct packed {
    logic            is_load;
    logic            is_store;
    logic [2:0]      func3;
    logic [7:0]      wsel;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [RD_W-1:0] rd;
  } op_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] data;
    logic [RD_W-1:0] rd;
    logic            is_load;
    logic            exc;
    logic [3:0]      code;
    logic [XLEN-1:0] val;
  } resp_t;

  lsu_state_e      state;
  op_t             op;
  resp_t           resp;
  logic [XLEN-1:0] ag_addr;
  logic [7:0]      ag_wsel;
  logic            ag_illegal;
  logic            issue;

  lsu_ctrl_addr_gen #(.XLEN(XLEN)) u_addr_gen (
    .base     (bus.req_base),
    .imm      (bus.req_imm),
    .func3    (bus.req_func3),
    .is_load  (bus.req_is_load),
    .is_store (bus.req_is_store),
    .addr     (ag_addr),
    .word_sel (ag_wsel),
    .illegal  (ag_illegal)
  );

  // FSM: accept op, one dmem cycle, hold result until writeback takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      op    <= '0;
      resp  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid && (bus.req_is_load || bus.req_is_store)) begin
            op.is_load  <= bus.req_is_load;
            op.is_store <= bus.req_is_store;
            op.func3    <= bus.req_func3;
            op.wsel     <= ag_wsel;
            op.addr     <= ag_addr;
            op.wdata    <= bus.req_is_store ? bus.req_wdata : '0;
            op.rd       <= bus.req_rd;
            if (ag_illegal) begin
              // Decode fault: never touches dmem.
              state        <= ST_RESP;
              resp.valid   <= 1'b1;
              resp.data    <= '0;
              resp.rd      <= bus.req_rd;
              resp.is_load <= 1'b0;
              resp.exc     <= 1'b1;
              resp.code    <= EXC_ILLEGAL;
              resp.val     <= '0;
            end else begin
              state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          state        <= ST_RESP;
          resp.valid   <= 1'b1;
          resp.data    <= bus.exc_en ? '0 : (op.is_load ? bus.dmem_data : '0);
          resp.rd      <= op.rd;
          resp.is_load <= op.is_load && !bus.exc_en;
          resp.exc     <= bus.exc_en;
          resp.code    <= bus.exc_en ? bus.exc_code : 4'd0;
          resp.val     <= bus.exc_en ? bus.exc_val : '0;
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            state <= ST_IDLE;
            resp  <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // dmem is driven only while in ISSUE, straight from latched state.
  assign issue             = (state == ST_ISSUE);
  assign bus.req_ready     = (state == ST_IDLE);
  assign bus.we_dmem       = issue && op.is_store;
  assign bus.is_LOAD       = issue && op.is_load;
  assign bus.dmem_word_sel = issue ? op.wsel  : '0;
  assign bus.r_dmem_addr   = issue ? op.addr  : '0;
  assign bus.w_dmem_data   = issue ? op.wdata : '0;
  assign bus.func3         = issue ? op.func3 : '0;

  assign bus.resp_valid    = resp.valid;
  assign bus.resp_data     = resp.data;
  assign bus.resp_rd       = resp.rd;
  assign bus.resp_is_load  = resp.is_load;
  assign bus.resp_exc      = resp.exc;
  assign bus.resp_exc_code = resp.code;
  assign bus.resp_exc_val  = resp.val;

`ifdef LSU_PERF_CNT_EN
  // Count each consumed response once: faulted ops (incl. illegal) as exc, else by type.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_load  <= '0;
      cnt_store <= '0;
      cnt_exc   <= '0;
    end else if (state == ST_RESP && bus.resp_ready) begin
      if (resp.exc)       cnt_exc   <= cnt_exc + 64'd1;
      else if (op.is_load) cnt_load  <= cnt_load + 64'd1;
      else                cnt_store <= cnt_store + 64'd1;
    end
  end
`endif
endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed spec cases plus random ops vs an op-level reference model.
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   ops_since_rst = 0;

  always #5 clk = ~clk;

  lsu_ctrl_if #(.XLEN(64), .RD_W(5)) bus ();

`ifdef LSU_PERF_CNT_EN
  logic [63:0] cnt_load, cnt_store, cnt_exc;
`endif

  lsu_ctrl #(.XLEN(64), .RD_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef LSU_PERF_CNT_EN
    ,
    .cnt_load  (cnt_load),
    .cnt_store (cnt_store),
    .cnt_exc   (cnt_exc)
`endif
  );

  // Byte memories: dm_mem is what the DUT actually wrote, ref_mem is what it should have.
  logic [7:0] dm_mem  [logic [63:0]];
  logic [7:0] ref_mem [logic [63:0]];

  function automatic logic [63:0] rd_bytes(input bit use_ref, input logic [63:0] a, input int n);
    logic [63:0] r;
    logic [63:0] k;
    logic [7:0]  b;
    r = '0;
    for (int i = 0; i < n; i++) begin
      k = a + 64'(i);
      if (use_ref) b = ref_mem.exists(k) ? ref_mem[k] : 8'h00;
      else         b = dm_mem.exists(k)  ? dm_mem[k]  : 8'h00;
      r = r | (64'(b) << (8 * i));
    end
    return r;
  endfunction

  task automatic wr_bytes(input bit use_ref, input logic [63:0] a, input int n, input logic [63:0] d);
    for (int i = 0; i < n; i++) begin
      if (use_ref) ref_mem[a + 64'(i)] = d[8*i +: 8];
      else         dm_mem[a + 64'(i)]  = d[8*i +: 8];
    end
  endtask

  // Memory map: RAM at 0x8000_0000..0x8000_FFFF, natural alignment required.
  function automatic logic [3:0] acc_exc(input logic ld, input logic [2:0] f3, input logic [63:0] a);
    int sz;
    sz = 1 << f3[1:0];
    if ((a % 64'(sz)) != 0) return ld ? EXC_LD_MISALIGN : EXC_ST_MISALIGN;
    if (a < 64'h8000_0000 || a >= 64'h8001_0000) return ld ? EXC_LD_FAULT : EXC_ST_FAULT;
    return 4'd0;
  endfunction

  function automatic logic [63:0] ld_ext(input logic [2:0] f3, input logic [63:0] raw);
    case (f3[1:0])
      2'd0:    return f3[2] ? {56'd0, raw[7:0]}  : {{56{raw[7]}}, raw[7:0]};
      2'd1:    return f3[2] ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      2'd2:    return f3[2] ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      default: return raw;
    endcase
  endfunction

  // Behavioural dmem: extended load data, misalign/fault exceptions, store commit on edge.
  always_comb begin
    logic [3:0] c;
    bus.dmem_data = '0;
    bus.exc_en    = 1'b0;
    bus.exc_code  = '0;
    bus.exc_val   = '0;
    c = acc_exc(bus.is_LOAD, bus.func3, bus.r_dmem_addr);
    if (bus.we_dmem || bus.is_LOAD) begin
      if (c != 4'd0) begin
        bus.exc_en   = 1'b1;
        bus.exc_code = c;
        bus.exc_val  = bus.r_dmem_addr;
      end else if (bus.is_LOAD) begin
        bus.dmem_data = ld_ext(bus.func3, rd_bytes(1'b0, bus.r_dmem_addr, 1 << bus.func3[1:0]));
      end
    end
  end

  always @(posedge clk)
    if (bus.we_dmem && !bus.exc_en)
      wr_bytes(1'b0, bus.r_dmem_addr, 1 << bus.func3[1:0], bus.w_dmem_data);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_resp(input logic [63:0] data, input logic [4:0] rd, input logic isl,
                          input logic exc, input logic [3:0] code, input logic [63:0] val);
    chk("resp_valid", 64'(bus.resp_valid), 64'd1);
    chk("resp_data", bus.resp_data, data);
    chk("resp_rd", 64'(bus.resp_rd), 64'(rd));
    chk("resp_is_load", 64'(bus.resp_is_load), 64'(isl));
    chk("resp_exc", 64'(bus.resp_exc), 64'(exc));
    chk("resp_exc_code", 64'(bus.resp_exc_code), 64'(code));
    chk("resp_exc_val", bus.resp_exc_val, val);
  endtask

  // One full op through the LSU; expected result derived from the op-level rules.
  task automatic do_op(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [63:0] base, input logic [63:0] imm,
                       input logic [63:0] wdata, input logic [4:0] rd, input int hold);
    logic [63:0] addr, e_data, e_val;
    logic [3:0]  e_code;
    logic        illegal, e_exc, e_isl;
    int          sz;
    addr    = base + imm;
    sz      = 1 << f3[1:0];
    illegal = (ld && st) || (ld && f3 == 3'b111) || (st && f3[2]);
    e_data  = '0; e_val = '0; e_code = '0; e_exc = 1'b0; e_isl = 1'b0;
    if (illegal) begin
      e_exc = 1'b1; e_code = EXC_ILLEGAL;
    end else begin
      e_code = acc_exc(ld, f3, addr);
      if (e_code != 4'd0) begin
        e_exc = 1'b1; e_val = addr;
      end else if (ld) begin
        e_isl  = 1'b1;
        e_data = ld_ext(f3, rd_bytes(1'b1, addr, sz));
      end else begin
        wr_bytes(1'b1, addr, sz, wdata);
      end
    end

    @(negedge clk);
    chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1; bus.req_is_load = ld; bus.req_is_store = st; bus.req_func3 = f3;
    bus.req_base = base; bus.req_imm = imm; bus.req_wdata = wdata; bus.req_rd = rd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (!illegal) begin
      chk("issue_we_dmem", 64'(bus.we_dmem), 64'(st));
      chk("issue_is_load", 64'(bus.is_LOAD), 64'(ld));
      chk("issue_word_sel", 64'(bus.dmem_word_sel), (64'd1 << sz) - 64'd1);
      chk("issue_addr", bus.r_dmem_addr, addr);
      chk("issue_wdata", bus.w_dmem_data, st ? wdata : 64'd0);
      chk("issue_func3", 64'(bus.func3), 64'(f3));
      chk("issue_resp_valid", 64'(bus.resp_valid), 64'd0);
      chk("issue_req_ready", 64'(bus.req_ready), 64'd0);
      @(posedge clk); #1;
    end
    chk("resp_we_dmem", 64'(bus.we_dmem), 64'd0);
    chk("resp_is_LOAD", 64'(bus.is_LOAD), 64'd0);
    chk("resp_dmem_addr", bus.r_dmem_addr, 64'd0);
    chk_resp(e_data, rd, e_isl, e_exc, e_code, e_val);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
      chk_resp(e_data, rd, e_isl, e_exc, e_code, e_val);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    ops_since_rst++;
    chk("after_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("after_req_ready", 64'(bus.req_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] a, imm;
    logic        ld, st;
    logic [2:0]  f3;
    bus.req_valid = 1'b0; bus.req_is_load = 1'b0; bus.req_is_store = 1'b0; bus.req_func3 = '0;
    bus.req_base = '0; bus.req_imm = '0; bus.req_wdata = '0; bus.req_rd = '0;
    bus.resp_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_we_dmem", 64'(bus.we_dmem), 64'd0);
    chk("rst_resp_data", bus.resp_data, 64'd0);
    chk("rst_word_sel", 64'(bus.dmem_word_sel), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);

    wr_bytes(1'b0, 64'h8000_2000, 2, 64'h00FF);
    wr_bytes(1'b1, 64'h8000_2000, 2, 64'h00FF);

    do_op(1, 0, F3_H,  64'h8000_2000, 64'd0, 64'd0, 5'd1, 0);
    do_op(1, 0, F3_B,  64'h8000_2000, 64'd0, 64'd0, 5'd2, 0);
    do_op(1, 0, F3_BU, 64'h8000_1000, 64'h1000, 64'd0, 5'd3, 0);
    do_op(0, 1, F3_D,  64'h8000_2000, 64'h1000, 64'h1122_3344_5566_7788, 5'd4, 0);
    do_op(1, 0, F3_D,  64'h8000_3010, 64'hFFFF_FFFF_FFFF_FFF0, 64'd0, 5'd5, 0);
    do_op(1, 0, F3_W,  64'h8000_2002, 64'd0, 64'd0, 5'd6, 0);
    do_op(0, 1, F3_W,  64'h7FFF_FFF0, 64'd0, 64'hDEAD_BEEF, 5'd7, 0);
    chk("fault_no_write", 64'(dm_mem.exists(64'h7FFF_FFF0)), 64'd0);
    do_op(1, 0, F3_WU, 64'h8000_3000, 64'd4, 64'd0, 5'd8, 3);
    do_op(1, 0, 3'b111, 64'h8000_3000, 64'd0, 64'd0, 5'd9, 0);
    do_op(1, 1, F3_W,  64'h8000_3000, 64'd0, 64'd0, 5'd10, 1);
    do_op(0, 1, F3_BU, 64'h8000_3000, 64'd0, 64'h55, 5'd11, 0);

    // Request with neither load nor store is ignored.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_is_load = 1'b0; bus.req_is_store = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("nop_req_ready", 64'(bus.req_ready), 64'd1);
    chk("nop_is_LOAD", 64'(bus.is_LOAD), 64'd0);
    @(posedge clk); #1;
    chk("nop_resp_valid", 64'(bus.resp_valid), 64'd0);

    // Reset in ISSUE of SD 0x80003008: write dropped at once, never committed.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_is_load = 1'b0; bus.req_is_store = 1'b1; bus.req_func3 = F3_D;
    bus.req_base = 64'h8000_3008; bus.req_imm = 64'd0; bus.req_wdata = 64'hCAFE_F00D_1234_5678;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("rsti_we_before", 64'(bus.we_dmem), 64'd1);
    rst = 1'b1;
    #1;
    chk("rsti_we_dmem", 64'(bus.we_dmem), 64'd0);
    chk("rsti_resp_valid", 64'(bus.resp_valid), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    ops_since_rst = 0;
    chk("rsti_no_write", 64'(dm_mem.exists(64'h8000_3008)), 64'd0);
    do_op(1, 0, F3_D, 64'h8000_3008, 64'd0, 64'd0, 5'd12, 0);

    // Random ops against the reference model.
    for (int n = 0; n < 40; n++) begin
      ld = 1'($urandom_range(0, 1));
      st = !ld || ($urandom_range(0, 9) == 0);
      f3 = 3'($urandom_range(0, 7));
      a  = 64'h8000_4000 + 64'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << f3[1:0]) - 64'd1);
      if ($urandom_range(0, 7) == 0) a = 64'h7FFF_FF00 + 64'($urandom_range(0, 15) * 8);
      imm = {32'($urandom), 32'($urandom)};
      do_op(ld, st, f3, a - imm, imm, {32'($urandom), 32'($urandom)},
            5'($urandom_range(0, 31)), int'($urandom_range(0, 2)));
    end

`ifdef LSU_PERF_CNT_EN
    chk("perf_total", cnt_load + cnt_store + cnt_exc, 64'(ops_since_rst));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
